rtc_cmd_sched: RTL and testbench

RTC_CMD_SCHED -- requirements
Module: rtc_cmd_sched

---
 rtl/rtc_cmd_sched.sv | 131 +++++++++++++
 tb/tb_rtc_cmd_sched.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_cmd_sched.sv
// Command scheduler for an RTC read/write engine: latches user and periodic
// requests, grants them one at a time by fixed priority and supervises each run.
module rtc_cmd_sched #(
   parameter int READ_PERIOD = 10000000,
   parameter int GAP_CYC     = 10,
   parameter int TIMEOUT     = 1000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_inic,
   input  logic       req_stop_ring,
   input  logic       req_hora,
   input  logic       req_fecha,
   input  logic       req_timer,
   input  logic       auto_read_en,
   input  logic       rtc_ready,
   output logic       eng_rst,
   output logic       inic,
   output logic       stop_ring,
   output logic       esc_hora,
   output logic       esc_fecha,
   output logic       esc_timer,
   output logic       leer,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [2:0] cur_cmd,
   output logic [1:0] state_dbg
);

   localparam int RW = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;
   localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [RW-1:0] RD_LAST  = RW'(READ_PERIOD - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state;
   logic [5:0]      pend;
   logic [5:0]      req_vec;
   logic [5:0]      grant_mask;
   logic [5:0]      cmd_lines;
   logic [2:0]      grant_code;
   logic            grant_ok;
   logic            rd_wrap;
   logic [RW-1:0]   rd_cnt;
   logic [GW-1:0]   gap_cnt;
   logic [TW-1:0]   tmo_cnt;

   // Handshake: a command line stays high for the whole RUN; the engine ends the
   // transaction with a one-cycle rtc_ready pulse, which is ignored outside RUN.
   assign rd_wrap   = auto_read_en && (rd_cnt == RD_LAST);
   assign req_vec   = {rd_wrap, req_timer, req_fecha, req_hora, req_stop_ring, req_inic};
   assign {leer, esc_timer, esc_fecha, esc_hora, stop_ring, inic} = cmd_lines;
   assign state_dbg = state;

   // Bit 0 (inic) has the highest priority; descending loop lets it win last.
   always_comb begin
      grant_mask = 6'd0;
      grant_code = 3'd0;
      for (int i = 5; i >= 0; i--) begin
         if (pend[i]) begin
            grant_mask = 6'd1 << i;
            grant_code = 3'(i + 1);
         end
      end
      grant_ok = (state == S_IDLE) && (pend != 6'd0) && (gap_cnt >= GAP_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_IDLE;
         pend      <= 6'b000001;
         rd_cnt    <= '0;
         gap_cnt   <= '0;
         tmo_cnt   <= '0;
         cmd_lines <= 6'd0;
         eng_rst   <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         cur_cmd   <= 3'd0;
      end else begin
         if (!auto_read_en || rd_cnt == RD_LAST) rd_cnt <= '0;
         else                                    rd_cnt <= rd_cnt + 1'b1;

         // A request landing on its own grant cycle re-arms the flag.
         pend <= (pend & ~(grant_ok ? grant_mask : 6'd0)) | req_vec;
         done <= 1'b0;

         case (state)
            S_IDLE: begin
               if (gap_cnt < GAP_LAST) gap_cnt <= gap_cnt + 1'b1;
               if (grant_ok) begin
                  state     <= S_RUN;
                  cmd_lines <= grant_mask;
                  cur_cmd   <= grant_code;
                  eng_rst   <= 1'b0;
                  busy      <= 1'b1;
                  tmo_cnt   <= '0;
               end
            end
            S_RUN: begin
               if (rtc_ready || tmo_cnt == TMO_LAST) begin
                  state     <= S_DONE;
                  cmd_lines <= 6'd0;
                  cur_cmd   <= 3'd0;
                  eng_rst   <= 1'b1;
                  busy      <= 1'b0;
                  done      <= rtc_ready;
                  err       <= !rtc_ready;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_DONE: begin
               state   <= S_IDLE;
               gap_cnt <= '0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rtc_cmd_sched.sv
// Bench for rtc_cmd_sched: directed scenarios plus a randomized run scored
// against a cycle-level behavioural model of the scheduling rules.
module tb_rtc_cmd_sched;

   localparam int RP  = 100;
   localparam int GAP = 10;
   localparam int TMO = 1000;

   logic clk = 1'b0;
   logic reset, req_inic, req_stop_ring, req_hora, req_fecha, req_timer;
   logic auto_read_en, rtc_ready;
   logic eng_rst, inic, stop_ring, esc_hora, esc_fecha, esc_timer, leer;
   logic busy, done, err;
   logic [2:0] cur_cmd;
   logic [1:0] state_dbg;
   logic [5:0] dut_lines;

   int checks = 0;
   int errors = 0;

   // model: pending set, phase (0 idle, 1 run, 2 done), elapsed cycle counts
   bit  m_pend[6];
   int  m_phase, m_idle, m_run, m_active, m_rd;
   bit  m_done, m_err;
   logic [2:0] exp_q[$];

   rtc_cmd_sched #(.READ_PERIOD(RP), .GAP_CYC(GAP), .TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset),
      .req_inic(req_inic), .req_stop_ring(req_stop_ring), .req_hora(req_hora),
      .req_fecha(req_fecha), .req_timer(req_timer),
      .auto_read_en(auto_read_en), .rtc_ready(rtc_ready),
      .eng_rst(eng_rst), .inic(inic), .stop_ring(stop_ring), .esc_hora(esc_hora),
      .esc_fecha(esc_fecha), .esc_timer(esc_timer), .leer(leer),
      .busy(busy), .done(done), .err(err), .cur_cmd(cur_cmd), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;
   assign dut_lines = {leer, esc_timer, esc_fecha, esc_hora, stop_ring, inic};

   function automatic void model_update(logic [4:0] r, bit rdy, bit ae, bit rst);
      int g;
      bit wrap;
      g = -1;
      if (rst) begin
         foreach (m_pend[i]) m_pend[i] = 1'b0;
         m_pend[0] = 1'b1;
         m_phase = 0; m_idle = 0; m_run = 0; m_active = 0; m_rd = 0;
         m_done = 1'b0; m_err = 1'b0;
      end else begin
         wrap = ae && (m_rd == RP - 1);
         m_rd = ae ? (m_rd + 1) % RP : 0;
         m_done = 1'b0;
         case (m_phase)
            0: begin
               for (int i = 5; i >= 0; i--) if (m_pend[i]) g = i;
               if (g >= 0 && m_idle >= GAP - 1) begin
                  m_phase = 1; m_active = g + 1; m_run = 0;
                  exp_q.push_back(3'(g + 1));
               end else begin
                  g = -1;
                  m_idle++;
               end
            end
            1: begin
               if (rdy) begin
                  m_phase = 2; m_done = 1'b1; m_err = 1'b0;
               end else if (m_run == TMO - 1) begin
                  m_phase = 2; m_err = 1'b1;
               end else begin
                  m_run++;
               end
            end
            default: begin
               m_phase = 0; m_idle = 0;
            end
         endcase
         if (g >= 0) m_pend[g] = 1'b0;
         for (int i = 0; i < 5; i++) if (r[i]) m_pend[i] = 1'b1;
         if (wrap) m_pend[5] = 1'b1;
      end
   endfunction

   function automatic logic [12:0] model_outputs();
      logic [2:0] c;
      logic [5:0] l;
      c = (m_phase == 1) ? 3'(m_active) : 3'd0;
      l = (m_phase == 1) ? (6'd1 << (m_active - 1)) : 6'd0;
      return {m_phase != 1, m_phase == 1, m_done, m_err, c, l};
   endfunction

   // One clock: inputs are captured, the edge happens, outputs are observed 1ns later.
   task automatic tick();
      logic [4:0] r;
      bit rdy, ae, rst;
      r   = {req_timer, req_fecha, req_hora, req_stop_ring, req_inic};
      rdy = rtc_ready;
      ae  = auto_read_en;
      rst = reset;
      @(posedge clk);
      #1;
      model_update(r, rdy, ae, rst);
   endtask

   task automatic clear_inputs();
      req_inic = 1'b0; req_stop_ring = 1'b0; req_hora = 1'b0;
      req_fecha = 1'b0; req_timer = 1'b0; rtc_ready = 1'b0;
   endtask

   task automatic wait_busy(input int limit, output int n, output bit ok);
      n = 0;
      ok = 1'b1;
      while (!busy) begin
         if (n >= limit) begin
            ok = 1'b0;
            return;
         end
         tick();
         n++;
      end
   endtask

   task automatic complete_run();
      rtc_ready = 1'b1;
      tick();
      rtc_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++;
      if ({eng_rst, busy, done, err} !== 4'b1000) begin
         errors++; $display("FAIL reset_ctrl got %b exp 1000", {eng_rst, busy, done, err});
      end
      checks++;
      if (dut_lines !== 6'd0) begin
         errors++; $display("FAIL reset_lines got %b exp 000000", dut_lines);
      end
      checks++;
      if (cur_cmd !== 3'd0 || state_dbg !== 2'd0) begin
         errors++; $display("FAIL reset_cmd got cur=%0d st=%0d exp 0 0", cur_cmd, state_dbg);
      end
   endtask

   task automatic test_init_sequence();
      int gap_bad;
      gap_bad = 0;
      reset = 1'b0;
      for (int k = 0; k < GAP; k++) begin
         if (eng_rst !== 1'b1 || busy !== 1'b0) gap_bad++;
         tick();
      end
      checks++;
      if (gap_bad != 0) begin
         errors++; $display("FAIL init_gap got %0d bad cycles exp 0", gap_bad);
      end
      checks++;
      if ({inic, busy, eng_rst, cur_cmd, dut_lines} !== {1'b1, 1'b1, 1'b0, 3'd1, 6'b000001}) begin
         errors++; $display("FAIL init_grant got inic=%b busy=%b eng_rst=%b cur=%0d lines=%b exp 1 1 0 1 000001",
                            inic, busy, eng_rst, cur_cmd, dut_lines);
      end
      repeat (3) tick();
      complete_run();
      checks++;
      if ({done, eng_rst, busy, err, cur_cmd, dut_lines} !== {4'b1100, 3'd0, 6'd0}) begin
         errors++; $display("FAIL init_done got done=%b eng_rst=%b busy=%b err=%b cur=%0d exp 1 1 0 0 0",
                            done, eng_rst, busy, err, cur_cmd);
      end
      tick();
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL init_done_pulse got done=%b exp 0", done);
      end
   endtask

   task automatic test_priority_pair();
      int n;
      bit ok;
      tick();
      req_hora = 1'b1; req_timer = 1'b1;
      tick();
      req_hora = 1'b0; req_timer = 1'b0;
      wait_busy(100, n, ok);
      checks++;
      if (!ok || cur_cmd !== 3'd3 || dut_lines !== 6'b000100) begin
         errors++; $display("FAIL pair_first got ok=%b cur=%0d lines=%b exp 1 3 000100", ok, cur_cmd, dut_lines);
      end
      repeat ($urandom_range(1, 5)) tick();
      complete_run();
      wait_busy(100, n, ok);
      checks++;
      if (!ok || n != GAP + 1) begin
         errors++; $display("FAIL pair_gap got %0d cycles exp %0d", n, GAP + 1);
      end
      checks++;
      if (cur_cmd !== 3'd5 || dut_lines !== 6'b010000) begin
         errors++; $display("FAIL pair_second got cur=%0d lines=%b exp 5 010000", cur_cmd, dut_lines);
      end
      complete_run();
      tick();
   endtask

   task automatic test_timeout();
      int n;
      bit ok;
      req_fecha = 1'b1;
      tick();
      req_fecha = 1'b0;
      wait_busy(100, n, ok);
      checks++;
      if (!ok || cur_cmd !== 3'd4) begin
         errors++; $display("FAIL tmo_grant got ok=%b cur=%0d exp 1 4", ok, cur_cmd);
      end
      n = 0;
      while (busy && n < TMO + 10) begin
         tick();
         n++;
      end
      checks++;
      if (n != TMO) begin
         errors++; $display("FAIL tmo_length got %0d cycles exp %0d", n, TMO);
      end
      checks++;
      if (err !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL tmo_flags got err=%b done=%b exp 1 0", err, done);
      end
      repeat (3) tick();
      checks++;
      if (err !== 1'b1) begin
         errors++; $display("FAIL tmo_sticky got err=%b exp 1", err);
      end
      req_hora = 1'b1;
      tick();
      req_hora = 1'b0;
      wait_busy(100, n, ok);
      complete_run();
      checks++;
      if (!ok || done !== 1'b1 || err !== 1'b0) begin
         errors++; $display("FAIL tmo_clear got ok=%b done=%b err=%b exp 1 1 0", ok, done, err);
      end
   endtask

   task automatic test_auto_read();
      int grants, run_cnt, leer_seen;
      bit prev_busy;
      grants = 0; run_cnt = 0; leer_seen = 0;
      repeat (20) tick();
      auto_read_en = 1'b1;
      prev_busy = busy;
      for (int c = 0; c < 450; c++) begin
         tick();
         if (busy && !prev_busy) begin
            grants++;
            checks++;
            if (cur_cmd !== 3'd6 || leer !== 1'b1) begin
               errors++; $display("FAIL auto_code got cur=%0d leer=%b exp 6 1", cur_cmd, leer);
            end
         end
         prev_busy = busy;
         run_cnt = busy ? run_cnt + 1 : 0;
         rtc_ready = busy && run_cnt == 3;
      end
      rtc_ready = 1'b0;
      checks++;
      if (grants != 4) begin
         errors++; $display("FAIL auto_count got %0d reads exp 4", grants);
      end
      auto_read_en = 1'b0;
      for (int c = 0; c < 300; c++) begin
         tick();
         if (leer) leer_seen++;
         rtc_ready = busy;
      end
      rtc_ready = 1'b0;
      checks++;
      if (leer_seen != 0) begin
         errors++; $display("FAIL auto_off got %0d leer cycles exp 0", leer_seen);
      end
   endtask

   task automatic test_merge();
      int n, stop_grants, other_grants;
      bit ok, prev_busy;
      stop_grants = 0; other_grants = 0;
      auto_read_en = 1'b1;
      wait_busy(200, n, ok);
      auto_read_en = 1'b0;
      checks++;
      if (!ok || cur_cmd !== 3'd6) begin
         errors++; $display("FAIL merge_leer got ok=%b cur=%0d exp 1 6", ok, cur_cmd);
      end
      for (int p = 0; p < 3; p++) begin
         req_stop_ring = 1'b1;
         tick();
         req_stop_ring = 1'b0;
         repeat (2) tick();
      end
      complete_run();
      prev_busy = busy;
      for (int c = 0; c < 200; c++) begin
         tick();
         if (busy && !prev_busy) begin
            if (cur_cmd == 3'd2) stop_grants++;
            else                 other_grants++;
         end
         prev_busy = busy;
         rtc_ready = busy;
      end
      rtc_ready = 1'b0;
      checks++;
      if (stop_grants != 1 || other_grants != 0) begin
         errors++; $display("FAIL merge_count got stop=%0d other=%0d exp 1 0", stop_grants, other_grants);
      end
   endtask

   task automatic test_reset_mid_run();
      int n, extra;
      bit ok, prev_busy;
      extra = 0;
      req_hora = 1'b1;
      tick();
      req_hora = 1'b0;
      wait_busy(100, n, ok);
      checks++;
      if (!ok || cur_cmd !== 3'd3) begin
         errors++; $display("FAIL rst_run_grant got ok=%b cur=%0d exp 1 3", ok, cur_cmd);
      end
      repeat (2) tick();
      reset = 1'b1;
      tick();
      checks++;
      if ({dut_lines, eng_rst, busy, cur_cmd} !== {6'd0, 1'b1, 1'b0, 3'd0}) begin
         errors++; $display("FAIL rst_abort got lines=%b eng_rst=%b busy=%b cur=%0d exp 000000 1 0 0",
                            dut_lines, eng_rst, busy, cur_cmd);
      end
      reset = 1'b0;
      req_fecha = 1'b1;
      tick();
      req_fecha = 1'b0;
      wait_busy(100, n, ok);
      checks++;
      if (!ok || cur_cmd !== 3'd1) begin
         errors++; $display("FAIL rst_inic_first got ok=%b cur=%0d exp 1 1", ok, cur_cmd);
      end
      complete_run();
      wait_busy(100, n, ok);
      checks++;
      if (!ok || cur_cmd !== 3'd4) begin
         errors++; $display("FAIL rst_then_fecha got ok=%b cur=%0d exp 1 4", ok, cur_cmd);
      end
      complete_run();
      prev_busy = busy;
      for (int c = 0; c < 100; c++) begin
         tick();
         if (busy && !prev_busy) extra++;
         prev_busy = busy;
         rtc_ready = busy;
      end
      rtc_ready = 1'b0;
      checks++;
      if (extra != 0) begin
         errors++; $display("FAIL rst_no_retry got %0d grants exp 0", extra);
      end
   endtask

   task automatic test_random();
      logic [12:0] exp_v, got_v;
      logic [2:0]  exp_c;
      bit prev_busy, idle_pend;
      int mism;
      mism = 0;
      exp_q.delete();
      prev_busy = busy;
      for (int c = 0; c < 4400; c++) begin
         if (c < 4000) begin
            req_inic      = ($urandom_range(0, 99) < 2);
            req_stop_ring = ($urandom_range(0, 99) < 3);
            req_hora      = ($urandom_range(0, 99) < 3);
            req_fecha     = ($urandom_range(0, 99) < 3);
            req_timer     = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) == 0) auto_read_en = !auto_read_en;
            rtc_ready     = ($urandom_range(0, 99) < (busy ? 15 : 5));
         end else begin
            clear_inputs();
            auto_read_en = 1'b0;
            rtc_ready = busy;
         end
         tick();
         exp_v = model_outputs();
         got_v = {eng_rst, busy, done, err, cur_cmd, dut_lines};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            mism++;
            if (mism <= 10)
               $display("FAIL rand_outputs cycle %0d got %b exp %b", c, got_v, exp_v);
         end
         if (busy && !prev_busy) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rand_sb got unexpected grant cur=%0d exp none", cur_cmd);
            end else begin
               exp_c = exp_q.pop_front();
               if (cur_cmd !== exp_c) begin
                  errors++; $display("FAIL rand_sb got cur=%0d exp %0d", cur_cmd, exp_c);
               end
            end
         end
         prev_busy = busy;
      end
      clear_inputs();
      idle_pend = 1'b0;
      foreach (m_pend[i]) if (m_pend[i]) idle_pend = 1'b1;
      checks++;
      if (exp_q.size() != 0 || idle_pend || busy !== 1'b0) begin
         errors++; $display("FAIL rand_drain got queue=%0d pending=%b busy=%b exp 0 0 0",
                            exp_q.size(), idle_pend, busy);
      end
   endtask

   initial begin
      reset = 1'b1;
      auto_read_en = 1'b0;
      clear_inputs();
      test_reset();
      test_init_sequence();
      test_priority_pair();
      test_timeout();
      test_auto_read();
      test_merge();
      test_reset_mid_run();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
